psum_accumulation_unit: RTL and testbench
=========================================

// Module: psum_accumulation_unit
// PURPOSE
//  Multi-filter partial-sum accumulator for the CNN PE; successor to the single-filter psum scratch pad + adder path.
//  Accepts a valid/ready product stream tagged {filter, addr, first, last} and does read-modify-write into a
//  NUM_FILTERS x PSUM_DEPTH psum store. On 'last' it emits the finished sum on a valid/ready result stream with backpressure.
// PARAMETERS
//  PROD_WIDTH   14  width of unsigned product input; must be <= PSUM_WIDTH
//  PSUM_WIDTH   32  width of stored/emitted psum
//  NUM_FILTERS  4   filters (channels) held concurrently; need not be a power of 2
//  PSUM_DEPTH   32  psum entries per filter; need not be a power of 2
//  FILT_W       $clog2(NUM_FILTERS) (min 1)  filter index width
//  ADDR_W       $clog2(PSUM_DEPTH)  (min 1)  entry address width
// PORTS
//  clk         in   1           clock
//  rst         in   1           synchronous, active-high reset
//  clear       in   1           sync pulse: invalidate all entries, clear overflow/err
//  in_valid    in   1           product beat valid
//  in_ready    out  1           unit can accept beat
//  in_prod     in   PROD_WIDTH  unsigned product
//  in_filter   in   FILT_W      target filter
//  in_addr     in   ADDR_W      target entry
//  in_first    in   1           ignore stored value (treat as 0)
//  in_last     in   1           final contribution: emit result, invalidate entry
//  out_valid   out  1           result valid
//  out_ready   in   1           consumer accepts result
//  out_data    out  PSUM_WIDTH  finished psum
//  out_filter  out  FILT_W      filter tag of result
//  out_addr    out  ADDR_W      entry tag of result
//  overflow    out  1           sticky: an addition exceeded 2^PSUM_WIDTH-1
//  err         out  1           sticky: out-of-range filter/addr beat received
// BEHAVIOUR
//  - Reset: s1_valid=0, out_valid=0, out_data/out_filter/out_addr=0, overflow=0, err=0, all entry valid bits=0; in_ready=1.
//  - Stage S1: beat captured on in_valid&in_ready. During S1 cycle: base = (in_first | !vbit[f][a]) ? 0 : store[f][a];
//    sum = base + zero-extended prod, computed PSUM_WIDTH+1 bits. S1 retires at clock edge when s1_adv=1:
//    store[f][a]<=sum, vbit<=!last; if last, output register loads {sum,f,a}.
//  - Single-cycle RMW: back-to-back beats to the same entry need no forwarding (write lands before next S1 read).
//  - s1_adv = s1_valid & (!s1_last | !out_valid | out_ready). in_ready = !s1_valid | s1_adv (combinational).
//  - Output: one-entry register; out_valid held, data stable until out_valid&out_ready. Accept and reload same cycle allowed.
//  - Latency: handshake in cycle t -> out_valid in cycle t+2 (no backpressure). Throughput 1 beat/cycle.
//  - Out of range (in_filter>=NUM_FILTERS or in_addr>=PSUM_DEPTH): beat accepted, no store write, no output, err<=1.
//  - clear: vbit all <=0, overflow<=0, err<=0. Beat retiring same cycle still writes data and emits output, but its entry
//    ends invalid (clear wins). S1/output registers unaffected.
//  - rst mid-operation: in-flight beat and pending output dropped; store data not cleared (vbits make it don't-care).
//  - Store: flops, combinational read; no reset of data array.
// CONFIGURATION
//  PSUM_SATURATE_EN defined: on carry, sum clamps to 2^PSUM_WIDTH-1; overflow<=1.
//  PSUM_SATURATE_EN undefined: sum wraps mod 2^PSUM_WIDTH; overflow<=1 on carry.
// TESTING
//  1. Assert rst 2 cycles -> in_ready=1, out_valid=0, overflow=0, err=0, out_data=0.
//  2. f=1,a=3: prod 5(first),7,9(last) back-to-back, out_ready=1 -> one result 21,f=1,a=3, out_valid 2 cycles after last beat; then 4(last,first=0) -> 4.
//  3. out_ready=0; last beats 10@a0 then 20@a1 -> out holds 10, second stalls in S1, in_ready=0; out_ready=1 -> 10 then 20, no loss/dup.
//  4. PSUM_WIDTH=8: 200(first),100(last) -> 44 & overflow=1 without macro; 255 & overflow=1 with PSUM_SATURATE_EN.
//  5. 10(first)@a0, pulse clear, 3(last,first=0)@a0 -> 3; overflow/err reset by clear.
//  6. NUM_FILTERS=3: beat f=3 -> accepted, err=1, no output, no entry altered; next valid beat processes normally.

Source files
------------

// File: rtl/psum_accumulation_unit.sv
// ============================================================================
// psum_accumulation_unit
// ----------------------------------------------------------------------------
// Multi-filter partial-sum accumulator for the CNN PE. A product stream tagged
// {filter, addr, first, last} is read-modify-written into a
// NUM_FILTERS x PSUM_DEPTH psum store. A beat marked 'last' emits the finished
// sum on a result stream with backpressure and invalidates its entry.
//
// Pipeline: input handshake -> S1 (store read, add, retire) -> output register.
// The store is flops with a combinational read. S1 writes back at the same
// edge at which it retires, so the next beat (even to the same entry) reads
// the updated value and no forwarding path is needed.
//
// Handshake semantics (both streams): a transfer happens on a rising clock
// edge where valid and ready are both 1. A producer holds valid and its
// payload stable until that transfer; ready may depend combinationally on the
// downstream ready (in_ready follows out_ready through s1_adv).
//
// Configuration macro:
//   PSUM_SATURATE_EN  defined   -> on carry out of the add, the sum clamps to
//                                  2^PSUM_WIDTH-1 and overflow is set.
//                     undefined -> the sum wraps mod 2^PSUM_WIDTH and overflow
//                                  is set.
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   clear       one-cycle pulse: invalidate all entries, clear overflow/err
//   in_valid    product beat valid
//   in_ready    unit can accept a beat
//   in_prod     unsigned product (PROD_WIDTH)
//   in_filter   target filter (FILT_W)
//   in_addr     target entry (ADDR_W)
//   in_first    ignore stored value for this beat (treat as 0)
//   in_last     final contribution: emit result and invalidate entry
//   out_valid   result valid
//   out_ready   consumer accepts result
//   out_data    finished psum (PSUM_WIDTH)
//   out_filter  filter tag of the result
//   out_addr    entry tag of the result
//   overflow    sticky: an addition carried out of PSUM_WIDTH bits
//   err         sticky: a beat with out-of-range filter/addr was received
// ============================================================================
module psum_accumulation_unit #(
    parameter int PROD_WIDTH  = 14,
    parameter int PSUM_WIDTH  = 32,
    parameter int NUM_FILTERS = 4,
    parameter int PSUM_DEPTH  = 32,
    parameter int FILT_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
    parameter int ADDR_W      = (PSUM_DEPTH > 1) ? $clog2(PSUM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] in_prod,
    input  logic [FILT_W-1:0]     in_filter,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PSUM_WIDTH-1:0] out_data,
    output logic [FILT_W-1:0]     out_filter,
    output logic [ADDR_W-1:0]     out_addr,
    output logic                  overflow,
    output logic                  err
);

    // Limits widened by one bit so the range compare never truncates the bound
    // (e.g. NUM_FILTERS=4 with FILT_W=2).
    localparam logic [FILT_W:0] FILT_LIMIT = NUM_FILTERS[FILT_W:0];
    localparam logic [ADDR_W:0] ADDR_LIMIT = PSUM_DEPTH[ADDR_W:0];

    // ------------------------------------------------------------------------
    // Psum store: data flops (never reset) plus per-entry valid bits.
    // ------------------------------------------------------------------------
    logic [PSUM_WIDTH-1:0] store [NUM_FILTERS][PSUM_DEPTH];
    logic                  vbit  [NUM_FILTERS][PSUM_DEPTH];

    // ------------------------------------------------------------------------
    // Stage S1 registers
    // ------------------------------------------------------------------------
    logic                  s1_valid;
    logic [PROD_WIDTH-1:0] s1_prod;
    logic [FILT_W-1:0]     s1_filter;
    logic [ADDR_W-1:0]     s1_addr;
    logic                  s1_first;
    logic                  s1_last;
    logic                  s1_oor;     // beat addressed a non-existent entry

    logic                  s1_adv;
    logic                  in_oor;
    logic                  emit;

    logic [FILT_W-1:0]     rd_filter;
    logic [ADDR_W-1:0]     rd_addr;
    logic [PSUM_WIDTH-1:0] base;
    logic [PSUM_WIDTH:0]   sum_ext;
    logic                  carry;
    logic [PSUM_WIDTH-1:0] sum_final;

    // ------------------------------------------------------------------------
    // Flow control. A 'last' beat needs the output register to be free (or
    // draining this cycle); other beats retire unconditionally.
    // ------------------------------------------------------------------------
    assign s1_adv   = s1_valid & (~s1_last | ~out_valid | out_ready);
    assign in_ready = ~s1_valid | s1_adv;

    assign in_oor = ({1'b0, in_filter} >= FILT_LIMIT) |
                    ({1'b0, in_addr}   >= ADDR_LIMIT);

    // Out-of-range beats never produce a result.
    assign emit = s1_adv & s1_last & ~s1_oor;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_prod   <= in_prod;
            s1_filter <= in_filter;
            s1_addr   <= in_addr;
            s1_first  <= in_first;
            s1_last   <= in_last;
            s1_oor    <= in_oor;
        end
    end

    // ------------------------------------------------------------------------
    // S1 datapath: read, add with one extra bit to capture the carry.
    // The read index is forced to 0 for out-of-range beats so the array is
    // never indexed past its bounds; the base is zeroed for them anyway.
    // ------------------------------------------------------------------------
    always_comb begin
        rd_filter = s1_oor ? '0 : s1_filter;
        rd_addr   = s1_oor ? '0 : s1_addr;
        base      = '0;
        if (!s1_oor && !s1_first && vbit[rd_filter][rd_addr]) begin
            base = store[rd_filter][rd_addr];
        end
        sum_ext = {1'b0, base} +
                  {{(PSUM_WIDTH + 1 - PROD_WIDTH){1'b0}}, s1_prod};
        carry   = sum_ext[PSUM_WIDTH];
    end

`ifdef PSUM_SATURATE_EN
    assign sum_final = carry ? {PSUM_WIDTH{1'b1}} : sum_ext[PSUM_WIDTH-1:0];
`else
    assign sum_final = sum_ext[PSUM_WIDTH-1:0];
`endif

    // ------------------------------------------------------------------------
    // Store write-back on retire. Data is written even for a 'last' beat;
    // the cleared valid bit makes the stale value a don't-care.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (s1_adv && !s1_oor) begin
            store[s1_filter][s1_addr] <= sum_final;
        end
    end

    // A clear in the same cycle as a retire overrides the retire's valid-bit
    // update: the later assignment in this block wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
                for (int a = 0; a < PSUM_DEPTH; a++) begin
                    vbit[f][a] <= 1'b0;
                end
            end
        end else begin
            if (s1_adv && !s1_oor) begin
                vbit[s1_filter][s1_addr] <= ~s1_last;
            end
            if (clear) begin
                for (int f = 0; f < NUM_FILTERS; f++) begin
                    for (int a = 0; a < PSUM_DEPTH; a++) begin
                        vbit[f][a] <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register: holds until accepted; accept and reload in one cycle
    // is allowed because s1_adv already counts out_ready as a free slot.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_filter <= '0;
            out_addr   <= '0;
        end else if (emit) begin
            out_valid  <= 1'b1;
            out_data   <= sum_final;
            out_filter <= s1_filter;
            out_addr   <= s1_addr;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky status flags; clear takes priority over a same-cycle event.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            err      <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
            err      <= 1'b0;
        end else if (s1_adv) begin
            if (s1_oor) begin
                err <= 1'b1;
            end else if (carry) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulation_unit.sv
// Bench for psum_accumulation_unit with an 8-bit psum, 3 filters and 5
// entries per filter, so wrap/saturation, out-of-range filter and
// out-of-range address are all reachable.
module tb_psum_accumulation_unit;

  localparam int PW   = 8;
  localparam int PRW  = 8;
  localparam int NF   = 3;
  localparam int DEP  = 5;
  localparam int FW   = 2;
  localparam int AW   = 3;
  localparam int RW   = PW + FW + AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           clear = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [PRW-1:0] in_prod = '0;
  logic [FW-1:0]  in_filter = '0;
  logic [AW-1:0]  in_addr = '0;
  logic           in_first = 1'b0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [PW-1:0]  out_data;
  logic [FW-1:0]  out_filter;
  logic [AW-1:0]  out_addr;
  logic           overflow;
  logic           err;

  psum_accumulation_unit #(
    .PROD_WIDTH  (PRW),
    .PSUM_WIDTH  (PW),
    .NUM_FILTERS (NF),
    .PSUM_DEPTH  (DEP),
    .FILT_W      (FW),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .in_filter  (in_filter),
    .in_addr    (in_addr),
    .in_first   (in_first),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_filter (out_filter),
    .out_addr   (out_addr),
    .overflow   (overflow),
    .err        (err)
  );

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [RW-1:0] pack(input int data, input int f, input int a);
    logic [PW-1:0] d;
    logic [FW-1:0] ff;
    logic [AW-1:0] aa;
    d  = data[PW-1:0];
    ff = f[FW-1:0];
    aa = a[AW-1:0];
    return {d, ff, aa};
  endfunction

  // Monitor: every accepted result is compared against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {19'd0, out_data, out_filter, out_addr}, 32'hffff_ffff);
        end else begin
          check("result", {19'd0, out_data, out_filter, out_addr}, {19'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int prod, input int f, input int a, input bit first, input bit last);
    int n;
    in_valid  = 1'b1;
    in_prod   = prod[PRW-1:0];
    in_filter = f[FW-1:0];
    in_addr   = a[AW-1:0];
    in_first  = first;
    in_last   = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    // 1. reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_err", err, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick(1);

    // 2. accumulate 5+7+9 = 21 at f1/a3, latency of two cycles after last beat
    exp_q.push_back(pack(21, 1, 3));
    send(5, 1, 3, 1, 0);
    send(7, 1, 3, 0, 0);
    send(9, 1, 3, 0, 1);
    check("lat_t1_out_valid", out_valid, 0);
    tick(1);
    check("lat_t2_out_valid", out_valid, 1);
    // entry invalidated by last: stored value ignored even though first=0
    exp_q.push_back(pack(4, 1, 3));
    send(4, 1, 3, 0, 1);
    tick(3);
    check("no_overflow_yet", overflow, 0);

    // 3. backpressure: second last beat stalls in S1, a third waits at input
    out_ready = 1'b0;
    exp_q.push_back(pack(10, 0, 0));
    exp_q.push_back(pack(20, 0, 1));
    exp_q.push_back(pack(1, 0, 2));
    send(10, 0, 0, 1, 1);
    send(20, 0, 1, 1, 1);
    tick(3);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_out_data", out_data, 10);
    fork
      send(1, 0, 2, 1, 1);
      begin
        tick(3);
        out_ready = 1'b1;
      end
    join
    tick(4);

    // 4. overflow: 200 + 100 in 8 bits
`ifdef PSUM_SATURATE_EN
    exp_q.push_back(pack(255, 2, 4));
`else
    exp_q.push_back(pack(44, 2, 4));
`endif
    send(200, 2, 4, 1, 0);
    send(100, 2, 4, 0, 1);
    tick(1);
    check("overflow_set", overflow, 1);
    tick(2);

    // 6. out-of-range filter and address: err, no output, entry untouched
    send(50, 0, 2, 1, 0);
    send(9, 3, 0, 1, 1);
    tick(1);
    check("err_set_filter", err, 1);
    send(9, 0, 5, 1, 1);
    exp_q.push_back(pack(57, 0, 2));
    send(7, 0, 2, 0, 1);
    tick(3);

    // 5. clear drops the pending accumulation and the sticky flags
    exp_q.push_back(pack(3, 0, 0));
    send(10, 0, 0, 1, 0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_overflow", overflow, 0);
    check("clear_err", err, 0);
    send(3, 0, 0, 0, 1);

    // drain
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    tick(2);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
